regfile_port_ctrl: RTL

//  Access controller for the bit-cell register file: the requester side of the wordline/bitline interface.

---
 rtl/regfile_port_ctrl_if.sv | 44 ++++
 rtl/regfile_port_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/regfile_port_ctrl_if.sv
// Request, wordline/bitline and response signals between the decode stage, the
// register-file access controller and the bit-cell array.
interface regfile_port_ctrl_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_src1;
    logic [ADDR_W-1:0]   req_src2;
    logic [ADDR_W-1:0]   req_dst;
    logic                req_wr;
    logic [DATA_W-1:0]   req_wdata;
    logic [NUM_REGS-1:0] wl_read1;
    logic [NUM_REGS-1:0] wl_read2;
    logic [NUM_REGS-1:0] wl_write;
    logic [DATA_W-1:0]   wdata_bus;
    logic [DATA_W-1:0]   bitline1;
    logic [DATA_W-1:0]   bitline2;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_data1;
    logic [DATA_W-1:0]   rsp_data2;

    // The controller owns the request/response endpoints and drives the array.
    modport master (
        input  req_valid, req_src1, req_src2, req_dst, req_wr, req_wdata,
        output req_ready,
        output wl_read1, wl_read2, wl_write, wdata_bus,
        input  bitline1, bitline2,
        output rsp_valid, rsp_data1, rsp_data2,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_src1, req_src2, req_dst, req_wr, req_wdata,
        input  req_ready,
        input  wl_read1, wl_read2, wl_write, wdata_bus,
        output bitline1, bitline2,
        input  rsp_valid, rsp_data1, rsp_data2,
        output rsp_ready
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register-file access controller: decodes one request into one-hot wordlines for a
// single DRIVE cycle, captures both read operands and returns them over valid/ready.
module regfile_port_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_R0  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_ctrl_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state;
    logic                wr_en;
    logic [DATA_W-1:0]   cap1;
    logic [DATA_W-1:0]   cap2;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

    assign bus.req_ready = (state == IDLE);

    // Writes to R0 never reach the array when R0 is hardwired to zero.
    assign wr_en = bus.req_wr && !(ZERO_R0 && (bus.req_dst == '0));

    // During DRIVE the live wordlines identify the addresses, so a shared bit between
    // the write and read vectors is exactly "write active and dst == src".
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        cap1 = bus.bitline1;
        cap2 = bus.bitline2;
        if (ZERO_R0 && bus.wl_read1[0])
            cap1 = '0;
        else if ((bus.wl_write & bus.wl_read1) != '0)
            cap1 = bus.wdata_bus;
        if (ZERO_R0 && bus.wl_read2[0])
            cap2 = '0;
        else if ((bus.wl_write & bus.wl_read2) != '0)
            cap2 = bus.wdata_bus;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.wl_read1  <= '0;
            bus.wl_read2  <= '0;
            bus.wl_write  <= '0;
            bus.wdata_bus <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data1 <= '0;
            bus.rsp_data2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.wl_read1  <= onehot(bus.req_src1);
                        bus.wl_read2  <= onehot(bus.req_src2);
                        bus.wl_write  <= wr_en ? onehot(bus.req_dst) : '0;
                        bus.wdata_bus <= bus.req_wdata;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    bus.rsp_data1 <= cap1;
                    bus.rsp_data2 <= cap2;
                    bus.rsp_valid <= 1'b1;
                    bus.wl_read1  <= '0;
                    bus.wl_read2  <= '0;
                    bus.wl_write  <= '0;
                    bus.wdata_bus <= '0;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
